// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the MSP430 operand fetch sequencer: register roles,
// addressing-mode encodings, sequencer state encoding and the latched request.
package operand_sequencer_pkg;

  localparam int unsigned REG_W      = 4;
  localparam int unsigned MODE_W     = 2;
  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned INCR_W     = 2;

  localparam logic [REG_W-1:0] PC_REG  = REG_W'(0);
  localparam logic [REG_W-1:0] SP_REG  = REG_W'(1);
  localparam logic [REG_W-1:0] CG1_REG = REG_W'(2);
  localparam logic [REG_W-1:0] CG2_REG = REG_W'(3);

  localparam logic [MODE_W-1:0] REGISTER_MODE               = 2'b00;
  localparam logic [MODE_W-1:0] INDEXED_MODE                = 2'b01;
  localparam logic [MODE_W-1:0] INDIRECT_MODE               = 2'b10;
  localparam logic [MODE_W-1:0] INDIRECT_AUTOINCREMENT_MODE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SRC_EXT = 3'd1,
    ST_SRC_MEM = 3'd2,
    ST_DST_EXT = 3'd3,
    ST_DST_MEM = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

  // Decoded instruction fields captured on an accepted start.
  typedef struct packed {
    logic              fmt;
    logic              bw;
    logic [REG_W-1:0]  sreg;
    logic [MODE_W-1:0] smode;
    logic [REG_W-1:0]  dreg;
    logic              dmode;
  } op_req_t;

  // Stack pointer always moves by a full word, even for byte instructions.
  function automatic logic [INCR_W-1:0] autoinc_step(input logic bw,
                                                      input logic [REG_W-1:0] reg_num);
    return (!bw || reg_num == SP_REG) ? INCR_W'(2) : INCR_W'(1);
  endfunction

endpackage

// File: rtl/operand_sequencer_cg_decode.sv
// Combinational constant-generator decode for the source and destination
// operand fields; R2/R3 produce constants instead of register or memory reads.
module operand_sequencer_cg_decode
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          CG_ENABLE = 1'b1
) (
  input  logic [REG_W-1:0]  src_reg,
  input  logic [MODE_W-1:0] src_mode,
  input  logic [REG_W-1:0]  dst_reg,
  input  logic              dst_mode,
  output logic [WIDTH-1:0]  src_value_c,
  output logic              src_hit_c,
  output logic [WIDTH-1:0]  dst_value_c,
  output logic              dst_hit_c
);

  always_comb begin
    src_value_c = '0;
    src_hit_c   = 1'b0;
    dst_value_c = '0;
    dst_hit_c   = 1'b0;
    if (CG_ENABLE) begin
      // R2 in register mode is SR and in indexed mode is absolute addressing.
      if (src_reg == CG1_REG) begin
        case (src_mode)
          INDIRECT_MODE: begin
            src_hit_c   = 1'b1;
            src_value_c = WIDTH'(4);
          end
          INDIRECT_AUTOINCREMENT_MODE: begin
            src_hit_c   = 1'b1;
            src_value_c = WIDTH'(8);
          end
          default: ;
        endcase
      end else if (src_reg == CG2_REG) begin
        src_hit_c = 1'b1;
        case (src_mode)
          REGISTER_MODE: src_value_c = '0;
          INDEXED_MODE:  src_value_c = WIDTH'(1);
          INDIRECT_MODE: src_value_c = WIDTH'(2);
          default:       src_value_c = '1;
        endcase
      end
      if (dst_reg == CG2_REG && dst_mode) begin
        dst_hit_c   = 1'b1;
        dst_value_c = WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Multi-cycle MSP430 operand fetch sequencer: resolves source and destination
// operands via constant generation, register read, extension words and memory.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          CG_ENABLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  Format,
  input  logic                  BW,
  input  logic [REG_W-1:0]      srcA,
  input  logic [REG_W-1:0]      dstA,
  input  logic [MODE_W-1:0]     As,
  input  logic                  Ad,
  input  logic [WIDTH-1:0]      srcRegVal,
  input  logic [WIDTH-1:0]      dstRegVal,
  input  logic [WIDTH-1:0]      pcIn,
  input  logic                  abort,
  output logic                  mem_req,
  output logic [WIDTH-1:0]      mem_addr,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      src,
  output logic [WIDTH-1:0]      dst,
  output logic [WIDTH-1:0]      dstAddr,
  output logic                  dstIsMem,
  output logic                  srcGenerated,
  output logic [WIDTH-1:0]      pcOut,
  output logic [INCR_W-1:0]     srcIncr
);

  seq_state_t state, state_n;
  op_req_t    req_q, req_n, req_in, req;

  logic [WIDTH-1:0]  src_n, dst_n, dst_addr_n, pc_n, mem_addr_n;
  logic              dst_is_mem_n, src_gen_n, busy_n, done_n, mem_req_n;
  logic [INCR_W-1:0] src_incr_n;

  logic [WIDTH-1:0] cg_src_value_c, cg_dst_value_c;
  logic             cg_src_hit_c, cg_dst_hit_c;

  logic [WIDTH-1:0] src_val_c, src_index_base_c, dst_index_base_c;
  logic [WIDTH-1:0] ext_sx_c, rdata_zx_c, pc_incr_c;
  logic             src_is_pc_c, src_imm_c, src_ext_c, src_mem_c, dst_ext_c;

  // Single-operand instructions carry their operand in the destination field.
  always_comb begin
    req_in       = '0;
    req_in.fmt   = Format;
    req_in.bw    = BW;
    req_in.sreg  = Format ? dstA : srcA;
    req_in.smode = As;
    req_in.dreg  = dstA;
    req_in.dmode = Ad;
  end

  assign req = (state == ST_IDLE) ? req_in : req_q;

  operand_sequencer_cg_decode #(
    .WIDTH     (WIDTH),
    .CG_ENABLE (CG_ENABLE)
  ) u_cg_decode (
    .src_reg     (req.sreg),
    .src_mode    (req.smode),
    .dst_reg     (req.dreg),
    .dst_mode    (req.dmode),
    .src_value_c (cg_src_value_c),
    .src_hit_c   (cg_src_hit_c),
    .dst_value_c (cg_dst_value_c),
    .dst_hit_c   (cg_dst_hit_c)
  );

  // Fetch plan for the current request.
  assign src_val_c   = req.fmt ? dstRegVal : srcRegVal;
  assign src_is_pc_c = (req.sreg == PC_REG);
  assign src_imm_c   = !cg_src_hit_c && (req.smode == INDIRECT_AUTOINCREMENT_MODE) && src_is_pc_c;
  assign src_ext_c   = !cg_src_hit_c && ((req.smode == INDEXED_MODE) || src_imm_c);
  assign src_mem_c   = !cg_src_hit_c && ((req.smode == INDIRECT_MODE) ||
                        ((req.smode == INDIRECT_AUTOINCREMENT_MODE) && !src_is_pc_c));
  assign dst_ext_c   = !req.fmt && req.dmode && !cg_dst_hit_c;

  // Index bases: R2 is absolute (base 0), R0 is relative to the extension word.
  assign src_index_base_c = (CG_ENABLE && req.sreg == CG1_REG) ? '0 :
                            src_is_pc_c ? pcOut : src_val_c;
  assign dst_index_base_c = (CG_ENABLE && req.dreg == CG1_REG) ? '0 : dstRegVal;

  assign ext_sx_c   = WIDTH'($signed(mem_rdata));
  assign rdata_zx_c = WIDTH'(mem_rdata);
  assign pc_incr_c  = pcOut + WIDTH'(2);

  always_comb begin
    state_n      = state;
    req_n        = req_q;
    src_n        = src;
    dst_n        = dst;
    dst_addr_n   = dstAddr;
    pc_n         = pcOut;
    mem_addr_n   = mem_addr;
    dst_is_mem_n = dstIsMem;
    src_gen_n    = srcGenerated;
    src_incr_n   = srcIncr;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    mem_req_n    = 1'b0;

    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            req_n        = req_in;
            pc_n         = pcIn;
            src_gen_n    = cg_src_hit_c;
            src_incr_n   = (src_mem_c && req.smode == INDIRECT_AUTOINCREMENT_MODE) ?
                           autoinc_step(req.bw, req.sreg) : '0;
            src_n        = cg_src_hit_c ? cg_src_value_c : src_val_c;
            dst_n        = cg_dst_hit_c ? cg_dst_value_c : dstRegVal;
            dst_addr_n   = '0;
            dst_is_mem_n = 1'b0;
            if (src_ext_c) begin
              state_n    = ST_SRC_EXT;
              mem_addr_n = pcIn;
            end else if (src_mem_c) begin
              state_n    = ST_SRC_MEM;
              mem_addr_n = src_val_c;
            end else if (dst_ext_c) begin
              state_n    = ST_DST_EXT;
              mem_addr_n = pcIn;
            end else begin
              state_n = ST_DONE;
            end
          end
        end
        ST_SRC_EXT: begin
          if (mem_ack) begin
            pc_n = pc_incr_c;
            if (src_imm_c) begin
              src_n = rdata_zx_c;
              if (dst_ext_c) begin
                state_n    = ST_DST_EXT;
                mem_addr_n = pc_incr_c;
              end else begin
                state_n = ST_DONE;
              end
            end else begin
              state_n    = ST_SRC_MEM;
              mem_addr_n = ext_sx_c + src_index_base_c;
            end
          end
        end
        ST_SRC_MEM: begin
          if (mem_ack) begin
            src_n = rdata_zx_c;
            if (dst_ext_c) begin
              state_n    = ST_DST_EXT;
              mem_addr_n = pcOut;
            end else begin
              state_n = ST_DONE;
            end
          end
        end
        ST_DST_EXT: begin
          if (mem_ack) begin
            pc_n       = pc_incr_c;
            dst_addr_n = ext_sx_c + dst_index_base_c;
            mem_addr_n = ext_sx_c + dst_index_base_c;
            state_n    = ST_DST_MEM;
          end
        end
        ST_DST_MEM: begin
          if (mem_ack) begin
            dst_n        = rdata_zx_c;
            dst_is_mem_n = 1'b1;
            state_n      = ST_DONE;
          end
        end
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end

    // Reads are always full words; byte lane selection happens downstream.
    mem_addr_n[0] = 1'b0;

    busy_n    = (state_n != ST_IDLE);
    done_n    = (state_n == ST_DONE);
    mem_req_n = (state_n == ST_SRC_EXT) || (state_n == ST_SRC_MEM) ||
                (state_n == ST_DST_EXT) || (state_n == ST_DST_MEM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      req_q        <= '0;
      src          <= '0;
      dst          <= '0;
      dstAddr      <= '0;
      pcOut        <= '0;
      mem_addr     <= '0;
      dstIsMem     <= 1'b0;
      srcGenerated <= 1'b0;
      srcIncr      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_req      <= 1'b0;
    end else begin
      state        <= state_n;
      req_q        <= req_n;
      src          <= src_n;
      dst          <= dst_n;
      dstAddr      <= dst_addr_n;
      pcOut        <= pc_n;
      mem_addr     <= mem_addr_n;
      dstIsMem     <= dst_is_mem_n;
      srcGenerated <= src_gen_n;
      srcIncr      <= src_incr_n;
      busy         <= busy_n;
      done         <= done_n;
      mem_req      <= mem_req_n;
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed self-checking bench for operand_sequencer (16-bit instance plus a
// 20-bit instance for the wide sign-extended address case).
module tb_operand_sequencer;

  logic clk;
  logic rst_n, start, start20, Format, BW, Ad, abort;
  logic [3:0]  srcA, dstA;
  logic [1:0]  As;
  logic [15:0] srcRegVal, dstRegVal, pcIn;
  logic        mem_req, mem_ack, busy, done, dstIsMem, srcGenerated;
  logic [15:0] mem_addr, mem_rdata, src, dst, dstAddr, pcOut;
  logic [1:0]  srcIncr;

  logic [19:0] srcRegVal20, dstRegVal20, pcIn20;
  logic        mem_req20, mem_ack20, busy20, done20, dstIsMem20, srcGenerated20;
  logic [19:0] mem_addr20, src20, dst20, dstAddr20, pcOut20;
  logic [15:0] mem_rdata20;
  logic [1:0]  srcIncr20;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] mem [int unsigned];
  logic [15:0] req_log[$];
  logic [19:0] req_log20[$];
  int unsigned waits;
  int unsigned wcnt;
  logic [15:0] cur_addr;
  logic        addr_ok;

  operand_sequencer #(.WIDTH(16), .CG_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Format(Format), .BW(BW),
    .srcA(srcA), .dstA(dstA), .As(As), .Ad(Ad),
    .srcRegVal(srcRegVal), .dstRegVal(dstRegVal), .pcIn(pcIn), .abort(abort),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .src(src), .dst(dst), .dstAddr(dstAddr),
    .dstIsMem(dstIsMem), .srcGenerated(srcGenerated), .pcOut(pcOut), .srcIncr(srcIncr)
  );

  operand_sequencer #(.WIDTH(20), .CG_ENABLE(1'b1)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start20), .Format(Format), .BW(BW),
    .srcA(srcA), .dstA(dstA), .As(As), .Ad(Ad),
    .srcRegVal(srcRegVal20), .dstRegVal(dstRegVal20), .pcIn(pcIn20), .abort(abort),
    .mem_req(mem_req20), .mem_addr(mem_addr20), .mem_rdata(mem_rdata20), .mem_ack(mem_ack20),
    .busy(busy20), .done(done20), .src(src20), .dst(dst20), .dstAddr(dstAddr20),
    .dstIsMem(dstIsMem20), .srcGenerated(srcGenerated20), .pcOut(pcOut20), .srcIncr(srcIncr20)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_rd(input int unsigned a);
    return mem.exists(a) ? mem[a] : (a[15:0] ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] log_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 16'hDEAD;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model for the 16-bit instance with programmable wait states.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; wcnt = 0; cur_addr = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (wcnt == 0) cur_addr = mem_addr;
        else if (mem_addr !== cur_addr) addr_ok = 1'b0;
        if (wcnt >= waits) begin
          mem_ack = 1'b1;
          mem_rdata = mem_rd(32'(mem_addr));
          req_log.push_back(mem_addr);
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Zero-wait memory model for the 20-bit instance.
  initial begin
    mem_ack20 = 1'b0; mem_rdata20 = '0;
    forever begin
      @(negedge clk);
      mem_ack20 = mem_req20;
      if (mem_req20) begin
        mem_rdata20 = mem_rd(32'(mem_addr20));
        req_log20.push_back(mem_addr20);
      end
    end
  end

  task automatic set_op(input logic fmt, input logic bw, input logic [3:0] sa, input logic [1:0] as_m,
                        input logic [3:0] da, input logic ad_m, input logic [15:0] sv,
                        input logic [15:0] dv, input logic [15:0] pc);
    Format = fmt; BW = bw; srcA = sa; As = as_m; dstA = da; Ad = ad_m;
    srcRegVal = sv; dstRegVal = dv; pcIn = pc;
  endtask

  // Called at a negedge: pulses start (or holds it) and waits for done.
  task automatic launch(input bit hold_start, output int lat, output bit busy_ok);
    req_log.delete();
    addr_ok = 1'b1;
    start = 1'b1;
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  bok;
    bit  seen_done;
    rst_n = 1'b0; start = 1'b0; start20 = 1'b0; abort = 1'b0; waits = 0; addr_ok = 1'b1;
    srcRegVal20 = '0; dstRegVal20 = '0; pcIn20 = '0;
    set_op(1'b0, 1'b0, 4'd0, 2'b00, 4'd0, 1'b0, 16'h0, 16'h0, 16'h0);

    mem[32'h1000] = 16'hFFFE; mem[32'h01FE] = 16'hBEEF;
    mem[32'h2000] = 16'h5A5A; mem[32'h2002] = 16'h0010; mem[32'h0310] = 16'hCAFE;
    mem[32'h0400] = 16'h1357; mem[32'h0500] = 16'h2468;
    mem[32'h3000] = 16'h0004; mem[32'h0104] = 16'h1111;
    mem[32'h3002] = 16'h0200; mem[32'h0200] = 16'h2222;
    mem[32'h4000] = 16'h0203; mem[32'h0202] = 16'h7777;
    mem[32'h0100] = 16'h8000; mem[32'h8000] = 16'h4321;

    repeat (2) @(negedge clk);
    check_eq("reset_flags", {busy, done, mem_req, dstIsMem, srcGenerated, srcIncr}, 64'h0);
    check_eq("reset_vals", {src, dst, dstAddr, pcOut}, 64'h0);
    check_eq("reset_addr", mem_addr, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // MOV #8, R5 via constant generator
    set_op(1'b0, 1'b0, 4'd2, 2'b11, 4'd5, 1'b0, 16'h0, 16'h1234, 16'h0800);
    launch(1'b0, lat, bok);
    check_eq("cg8_lat", lat, 1);
    check_eq("cg8_src", src, 16'h0008);
    check_eq("cg8_gen", srcGenerated, 1'b1);
    check_eq("cg8_dst", dst, 16'h1234);
    check_eq("cg8_nreq", req_log.size(), 0);
    check_eq("cg8_pc", pcOut, 16'h0800);

    // R3 constant -1 source with R3 indexed destination (generated 1)
    @(negedge clk);
    set_op(1'b0, 1'b0, 4'd3, 2'b11, 4'd3, 1'b1, 16'h0, 16'h5555, 16'h0900);
    launch(1'b0, lat, bok);
    check_eq("cgm1_lat", lat, 1);
    check_eq("cgm1_src", src, 16'hFFFF);
    check_eq("cgm1_dst", dst, 16'h0001);
    check_eq("cgm1_dmem", dstIsMem, 1'b0);

    // Indexed source with negative offset
    @(negedge clk);
    set_op(1'b0, 1'b0, 4'd4, 2'b01, 4'd5, 1'b0, 16'h0200, 16'h0077, 16'h1000);
    launch(1'b0, lat, bok);
    check_eq("idx_lat", lat, 3);
    check_eq("idx_a0", log_at(0), 16'h1000);
    check_eq("idx_a1", log_at(1), 16'h01FE);
    check_eq("idx_src", src, 16'hBEEF);
    check_eq("idx_pc", pcOut, 16'h1002);
    check_eq("idx_busy", bok, 1'b1);

    // Immediate source + indexed destination, 2 wait states
    @(negedge clk);
    waits = 2;
    set_op(1'b0, 1'b0, 4'd0, 2'b11, 4'd7, 1'b1, 16'h0, 16'h0300, 16'h2000);
    launch(1'b0, lat, bok);
    check_eq("imm_lat", lat, 10);
    check_eq("imm_nreq", req_log.size(), 3);
    check_eq("imm_a2", log_at(2), 16'h0310);
    check_eq("imm_hold", addr_ok, 1'b1);
    check_eq("imm_src", src, 16'h5A5A);
    check_eq("imm_dst", dst, 16'hCAFE);
    check_eq("imm_daddr", dstAddr, 16'h0310);
    check_eq("imm_dmem", dstIsMem, 1'b1);
    check_eq("imm_pc", pcOut, 16'h2004);
    check_eq("imm_incr", srcIncr, 2'd0);
    waits = 0;

    // Autoincrement step: byte on R6, then byte on SP
    @(negedge clk);
    set_op(1'b0, 1'b1, 4'd6, 2'b11, 4'd5, 1'b0, 16'h0400, 16'h0, 16'h0);
    launch(1'b0, lat, bok);
    check_eq("ai6_lat", lat, 2);
    check_eq("ai6_src", src, 16'h1357);
    check_eq("ai6_incr", srcIncr, 2'd1);
    @(negedge clk);
    set_op(1'b0, 1'b1, 4'd1, 2'b11, 4'd5, 1'b0, 16'h0500, 16'h0, 16'h0);
    launch(1'b0, lat, bok);
    check_eq("ai1_src", src, 16'h2468);
    check_eq("ai1_incr", srcIncr, 2'd2);

    // Worst case: indexed src + absolute dst; start held high while busy
    @(negedge clk);
    set_op(1'b0, 1'b0, 4'd5, 2'b01, 4'd2, 1'b1, 16'h0100, 16'h9999, 16'h3000);
    launch(1'b1, lat, bok);
    check_eq("wc_lat", lat, 5);
    check_eq("wc_nreq", req_log.size(), 4);
    check_eq("wc_src", src, 16'h1111);
    check_eq("wc_dst", dst, 16'h2222);
    check_eq("wc_daddr", dstAddr, 16'h0200);
    check_eq("wc_pc", pcOut, 16'h3004);
    check_eq("wc_busy", bok, 1'b1);
    @(negedge clk);
    check_eq("wc_idle", busy, 1'b0);

    // Single-operand absolute with odd address -> word-aligned read
    @(negedge clk);
    set_op(1'b1, 1'b0, 4'd9, 2'b01, 4'd2, 1'b1, 16'h0, 16'h0, 16'h4000);
    launch(1'b0, lat, bok);
    check_eq("fmt1_lat", lat, 3);
    check_eq("fmt1_a1", log_at(1), 16'h0202);
    check_eq("fmt1_src", src, 16'h7777);
    check_eq("fmt1_pc", pcOut, 16'h4002);

    // Abort coincident with mem_ack in SRC_MEM
    @(negedge clk);
    set_op(1'b0, 1'b0, 4'd5, 2'b10, 4'd5, 1'b0, 16'h0600, 16'h0, 16'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("abt_req_pre", mem_req, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abt_state", {busy, done, mem_req}, 3'b000);
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check_eq("abt_nodone", seen_done, 1'b0);

    // Asynchronous reset during DST_EXT, then normal operation
    @(negedge clk);
    waits = 2;
    set_op(1'b0, 1'b0, 4'd5, 2'b00, 4'd6, 1'b1, 16'h0700, 16'h0800, 16'h5000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("rst_pre_req", {mem_req, mem_addr}, {1'b1, 16'h5000});
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_flags", {busy, done, mem_req, dstIsMem, srcGenerated, srcIncr}, 64'h0);
    check_eq("rst_mid_vals", {src, dst, dstAddr, pcOut}, 64'h0);
    check_eq("rst_mid_addr", mem_addr, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    waits = 0;
    @(negedge clk);
    set_op(1'b0, 1'b0, 4'd3, 2'b01, 4'd4, 1'b0, 16'h0, 16'h0042, 16'h0);
    launch(1'b0, lat, bok);
    check_eq("post_lat", lat, 1);
    check_eq("post_vals", {src, dst, srcGenerated}, {16'h0001, 16'h0042, 1'b1});

    // 20-bit instance: sign-extended offset wraps modulo 2^20
    @(negedge clk);
    set_op(1'b0, 1'b0, 4'd4, 2'b01, 4'd5, 1'b0, 16'h0, 16'h0, 16'h0);
    srcRegVal20 = 20'h10000; pcIn20 = 20'h00100;
    req_log20.delete();
    start20 = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start20 = 1'b0;
      lat++;
      if (done20) break;
    end
    check_eq("w20_lat", lat, 3);
    check_eq("w20_addr", (req_log20.size() > 1) ? req_log20[1] : 20'hFFFFF, 20'h08000);
    check_eq("w20_src", src20, 20'h04321);
    check_eq("w20_pc", pcOut20, 20'h00102);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
